// File: rtl/decode_ascii_hex_pkg.sv
// Shared constants for the ASCII-to-7-segment path: segment table, blank code,
// letter ranges and the keyboard-layout character mapping.
package decode_ascii_hex_pkg;

  localparam logic [7:0] CHR_LA   = 8'h61;  // 'a'
  localparam logic [7:0] CHR_LZ   = 8'h7A;  // 'z'
  localparam logic [7:0] CHR_UA   = 8'h41;  // 'A'
  localparam logic [7:0] CHR_UZ   = 8'h5A;  // 'Z'
  localparam logic [7:0] CHR_D0   = 8'h30;  // '0'
  localparam logic [7:0] CHR_D9   = 8'h39;  // '9'
  localparam logic [7:0] CASE_OFS = 8'h20;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segments, bit0=a .. bit6=g; element [n] is the glyph for nibble n.
  localparam logic [15:0][6:0] SEG_TBL = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // US layout symbols sitting above the number row.
  function automatic logic [7:0] shift_digit(input logic [3:0] d);
    logic [7:0] c;
    case (d)
      4'd1:    c = 8'h21;
      4'd2:    c = 8'h40;
      4'd3:    c = 8'h23;
      4'd4:    c = 8'h24;
      4'd5:    c = 8'h25;
      4'd6:    c = 8'h5E;
      4'd7:    c = 8'h26;
      4'd8:    c = 8'h2A;
      4'd9:    c = 8'h28;
      default: c = 8'h29;
    endcase
    return c;
  endfunction

  function automatic logic [7:0] eff_char(input logic [7:0] a, input logic caps,
                                          input logic shift);
    logic [7:0] c;
    c = a;
    if (shift && a >= CHR_D0 && a <= CHR_D9)
      c = shift_digit(a[3:0]);
    else if ((caps ^ shift) && a >= CHR_LA && a <= CHR_LZ)
      c = a - CASE_OFS;
    else if ((caps ^ shift) && a >= CHR_UA && a <= CHR_UZ)
      c = a + CASE_OFS;
    return c;
  endfunction

endpackage

// File: rtl/decode_ascii_hex_hex.sv
// Combinational nibble-to-segment decoder (active-low glyphs, blank when disabled).
module decode_hex
  import decode_ascii_hex_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       en,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (en) seg = SEG_TBL[nibble];
  end

endmodule

// File: rtl/decode_ascii_hex.sv
// Maps a raw key code through caps/shift to the effective character and
// registers it together with its two hex digits on 7-segment displays.
module decode_ascii_hex
  import decode_ascii_hex_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ascii,
  input  logic       en,
  input  logic       caps,
  input  logic       shift,
  output logic [7:0] ascii_out,
  output logic [6:0] hex_lo,
  output logic [6:0] hex_hi
);

  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? SEG_BLANK : ~SEG_BLANK;

  logic [7:0]      chr_nxt;
  logic            dig_en;
  logic [1:0][6:0] seg_raw;
  logic [1:0][6:0] seg_nxt;

  assign chr_nxt = eff_char(ascii, caps, shift);
  // NUL renders blank so an idle keyboard shows nothing rather than "00".
  assign dig_en  = en && (chr_nxt != 8'h00);

  for (genvar g = 0; g < 2; g++) begin : g_dig
    decode_hex u_dec (
      .nibble (chr_nxt[g*4 +: 4]),
      .en     (dig_en),
      .seg    (seg_raw[g])
    );
    assign seg_nxt[g] = ACTIVE_LOW ? seg_raw[g] : ~seg_raw[g];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ascii_out <= 8'h00;
      hex_lo    <= SEG_OFF;
      hex_hi    <= SEG_OFF;
    end else begin
      ascii_out <= chr_nxt;
      hex_lo    <= seg_nxt[0];
      hex_hi    <= seg_nxt[1];
    end
  end

endmodule

// File: tb/tb_decode_ascii_hex.sv
// Self-checking bench: directed cases, full code sweep and random traffic
// against a character-level reference model, on both output polarities.
module tb_decode_ascii_hex;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] ascii;
  logic       en, caps, shift;
  logic [7:0] ascii_out, ascii_out_ah;
  logic [6:0] hex_lo, hex_hi, hex_lo_ah, hex_hi_ah;

  int n_chk  = 0;
  int n_fail = 0;

  logic [21:0] cur_exp, cur_exp_ah;

  localparam logic [6:0] REF_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  decode_ascii_hex dut (
    .clk(clk), .reset(reset), .ascii(ascii), .en(en), .caps(caps), .shift(shift),
    .ascii_out(ascii_out), .hex_lo(hex_lo), .hex_hi(hex_hi)
  );

  decode_ascii_hex #(.ACTIVE_LOW(1'b0)) dut_ah (
    .clk(clk), .reset(reset), .ascii(ascii), .en(en), .caps(caps), .shift(shift),
    .ascii_out(ascii_out_ah), .hex_lo(hex_lo_ah), .hex_hi(hex_hi_ah)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_char(input logic [7:0] a, input logic c, input logic s);
    string sym = ")!@#$%^&*(";
    int    code = int'(a);
    if (s && code >= 48 && code <= 57) return sym[code - 48];
    if (c != s) begin
      if (code >= 97 && code <= 122) return 8'(code - 32);
      if (code >= 65 && code <= 90)  return 8'(code + 32);
    end
    return a;
  endfunction

  // Packed as {ascii_out, hex_hi, hex_lo}.
  function automatic logic [21:0] ref_out(input logic [7:0] a, input logic c, input logic s,
                                          input logic e, input bit low);
    logic [7:0] ch = ref_char(a, c, s);
    logic [6:0] hi = 7'h7F, lo = 7'h7F;
    if (e && ch != 8'h00) begin
      hi = REF_SEG[ch / 16];
      lo = REF_SEG[ch % 16];
    end
    if (!low) begin hi = ~hi; lo = ~lo; end
    return {ch, hi, lo};
  endfunction

  localparam logic [21:0] RST_LO = {8'h00, 7'h7F, 7'h7F};
  localparam logic [21:0] RST_HI = {8'h00, 7'h00, 7'h00};

  // Called at a negedge: outputs must hold until the next rising edge, then
  // reflect the new inputs exactly one edge later.
  task automatic step(input string tag, input logic [7:0] a, input logic c, input logic s,
                      input logic e);
    ascii = a; caps = c; shift = s; en = e;
    #1;
    check({tag, "_hold"},    {ascii_out, hex_hi, hex_lo},          cur_exp);
    check({tag, "_hold_ah"}, {ascii_out_ah, hex_hi_ah, hex_lo_ah}, cur_exp_ah);
    cur_exp    = ref_out(a, c, s, e, 1'b1);
    cur_exp_ah = ref_out(a, c, s, e, 1'b0);
    @(posedge clk); #1;
    check(tag,           {ascii_out, hex_hi, hex_lo},          cur_exp);
    check({tag, "_ah"},  {ascii_out_ah, hex_hi_ah, hex_lo_ah}, cur_exp_ah);
    @(negedge clk);
  endtask

  task automatic async_reset(input string tag);
    reset = 1'b1;
    #1;
    cur_exp = RST_LO; cur_exp_ah = RST_HI;
    check(tag,          {ascii_out, hex_hi, hex_lo},          cur_exp);
    check({tag, "_ah"}, {ascii_out_ah, hex_hi_ah, hex_lo_ah}, cur_exp_ah);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ascii = 8'h55; en = 1'b1; caps = 1'b0; shift = 1'b0;
    #2;
    cur_exp = RST_LO; cur_exp_ah = RST_HI;
    check("reset",    {ascii_out, hex_hi, hex_lo},          cur_exp);
    check("reset_ah", {ascii_out_ah, hex_hi_ah, hex_lo_ah}, cur_exp_ah);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    step("a_caps", 8'h61, 1'b1, 1'b0, 1'b1);
    check("a_caps_lit", {ascii_out, hex_hi, hex_lo}, {8'h41, 7'h19, 7'h79});
    step("one_shift", 8'h31, 1'b0, 1'b1, 1'b1);
    check("one_shift_lit", {ascii_out, hex_hi, hex_lo}, {8'h21, 7'h24, 7'h79});
    step("a_caps_shift", 8'h61, 1'b1, 1'b1, 1'b1);
    check("a_caps_shift_lit", ascii_out, 8'h61);
    step("brace_caps", 8'h7B, 1'b1, 1'b0, 1'b1);
    check("brace_caps_lit", {ascii_out, hex_hi, hex_lo}, {8'h7B, 7'h78, 7'h03});
    step("at_caps", 8'h40, 1'b1, 1'b0, 1'b1);
    check("at_caps_lit", {ascii_out, hex_hi, hex_lo}, {8'h40, 7'h19, 7'h40});
    step("en_off", 8'h37, 1'b0, 1'b0, 1'b0);
    check("en_off_lit", {ascii_out, hex_hi, hex_lo}, {8'h37, 7'h7F, 7'h7F});
    step("nul", 8'h00, 1'b1, 1'b1, 1'b1);
    check("nul_lit", {ascii_out, hex_hi, hex_lo}, {8'h00, 7'h7F, 7'h7F});
    step("bnd_5b", 8'h5B, 1'b0, 1'b1, 1'b1);
    step("bnd_60", 8'h60, 1'b1, 1'b0, 1'b1);
    step("Z_shift", 8'h5A, 1'b0, 1'b1, 1'b1);
    step("zero_caps_shift", 8'h30, 1'b1, 1'b1, 1'b1);
    check("zero_caps_shift_lit", ascii_out, 8'h29);

    // Reset landing between edges must clear immediately.
    @(posedge clk); #2;
    async_reset("reset_mid");

    for (int m = 0; m < 4; m++)
      for (int code = 0; code < 256; code++)
        step("sweep", 8'(code), m[1], m[0], 1'b1);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) async_reset("reset_rand");
      step("rand", 8'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 7) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
